// File: rtl/bus_datapath_seq.sv
// ============================================================================
// Module      : bus_datapath_seq
// Description : Single-bus CPU datapath with built-in T-state sequencer,
//               req/ack memory port and debug register read-out.
//               Optional multiplier enabled by macro DATAPATH_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_datapath_seq #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                     clock,
    input  logic                     clear,
    output logic [WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic                     mem_rd,
    output logic                     mem_wr,
    input  logic                     mem_ack,
    output logic                     halted,
    output logic                     illegal_op,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         ir,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int c_REG_AW = $clog2(NREGS);
    localparam int c_RA_LSB = WIDTH - 5 - c_REG_AW;
    localparam int c_RB_LSB = c_RA_LSB - c_REG_AW;
    localparam int c_RC_LSB = c_RB_LSB - c_REG_AW;

    localparam logic [3:0] c_F0  = 4'd0;
    localparam logic [3:0] c_F1  = 4'd1;
    localparam logic [3:0] c_F2  = 4'd2;
    localparam logic [3:0] c_E0  = 4'd3;
    localparam logic [3:0] c_E1  = 4'd4;
    localparam logic [3:0] c_E2  = 4'd5;
    localparam logic [3:0] c_M1  = 4'd6;
    localparam logic [3:0] c_M2  = 4'd7;
    localparam logic [3:0] c_HLT = 4'd8;

    localparam logic [4:0] c_OP_ADD  = 5'd0;
    localparam logic [4:0] c_OP_SUB  = 5'd1;
    localparam logic [4:0] c_OP_AND  = 5'd2;
    localparam logic [4:0] c_OP_OR   = 5'd3;
    localparam logic [4:0] c_OP_SHL  = 5'd4;
    localparam logic [4:0] c_OP_SHR  = 5'd5;
    localparam logic [4:0] c_OP_NOT  = 5'd6;
    localparam logic [4:0] c_OP_MUL  = 5'd7;
    localparam logic [4:0] c_OP_MFHI = 5'd8;
    localparam logic [4:0] c_OP_MFLO = 5'd9;
    localparam logic [4:0] c_OP_LD   = 5'd10;
    localparam logic [4:0] c_OP_ST   = 5'd11;
    localparam logic [4:0] c_OP_LDI  = 5'd12;
    localparam logic [4:0] c_OP_HALT = 5'd31;

    logic [3:0]          r_state;
    logic [3:0]          w_stateNext;
    logic [WIDTH-1:0]    r_regs [NREGS];
    logic [WIDTH-1:0]    r_pc, r_ir, r_mar, r_mdr, r_y, r_zHi, r_zLo, r_hi, r_lo;
    logic [4:0]          w_op;
    logic [c_REG_AW-1:0] w_ra, w_rb, w_rc;
    logic [WIDTH-1:0]    w_imm, w_raData, w_rbData, w_rcData, w_aluHi, w_aluLo;
    logic                w_legal, w_useAlu;

    assign w_op     = r_ir[WIDTH-1 -: 5];
    assign w_ra     = r_ir[c_RA_LSB +: c_REG_AW];
    assign w_rb     = r_ir[c_RB_LSB +: c_REG_AW];
    assign w_rc     = r_ir[c_RC_LSB +: c_REG_AW];
    assign w_raData = r_regs[w_ra];
    assign w_rbData = r_regs[w_rb];
    assign w_rcData = r_regs[w_rc];

    always_comb begin
        w_imm = '0;
        w_imm[c_RA_LSB-1:0] = r_ir[c_RA_LSB-1:0];
    end

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHL, c_OP_SHR, c_OP_NOT,
            c_OP_MFHI, c_OP_MFLO, c_OP_LD, c_OP_ST, c_OP_LDI, c_OP_HALT: w_legal = 1'b1;
`ifdef DATAPATH_MUL_EN
            c_OP_MUL: w_legal = 1'b1;
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // Opcodes 0..7 all take the Y/Z path; MUL only counts when it is legal.
    assign w_useAlu = w_legal && (w_op <= c_OP_MUL);

    always_comb begin
        w_aluHi = '0;
        w_aluLo = '0;
        case (w_op)
            c_OP_ADD: w_aluLo = r_y + w_rcData;
            c_OP_SUB: w_aluLo = r_y - w_rcData;
            c_OP_AND: w_aluLo = r_y & w_rcData;
            c_OP_OR:  w_aluLo = r_y | w_rcData;
            c_OP_SHL: w_aluLo = r_y << w_rcData[SHAMT_W-1:0];
            c_OP_SHR: w_aluLo = r_y >> w_rcData[SHAMT_W-1:0];
            c_OP_NOT: w_aluLo = ~r_y;
`ifdef DATAPATH_MUL_EN
            c_OP_MUL: {w_aluHi, w_aluLo} = {{WIDTH{1'b0}}, r_y} * {{WIDTH{1'b0}}, w_rcData};
`endif
            default: w_aluLo = '0;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_F0: w_stateNext = c_F1;
            c_F1: w_stateNext = mem_ack ? c_F2 : c_F1;
            c_F2: w_stateNext = c_E0;
            c_E0: begin
                if (!w_legal)                               w_stateNext = c_F0;
                else if (w_useAlu)                          w_stateNext = c_E1;
                else if (w_op == c_OP_LD || w_op == c_OP_ST) w_stateNext = c_M1;
                else if (w_op == c_OP_HALT)                 w_stateNext = c_HLT;
                else                                        w_stateNext = c_F0;
            end
            c_E1: w_stateNext = c_E2;
            c_E2: w_stateNext = c_F0;
            c_M1: begin
                if (mem_ack) w_stateNext = (w_op == c_OP_LD) ? c_M2 : c_F0;
            end
            c_M2:  w_stateNext = c_F0;
            c_HLT: w_stateNext = c_HLT;
            default: w_stateNext = c_F0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= c_F0;
        else        r_state <= w_stateNext;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_zHi <= '0;
            r_zLo <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            case (r_state)
                c_F0: begin
                    r_mar <= r_pc;
                    r_zLo <= r_pc + 1'b1;
                    r_pc  <= r_pc + 1'b1;
                end
                c_F1: if (mem_ack) r_mdr <= mem_rdata;
                c_F2: r_ir <= r_mdr;
                c_E0: begin
                    if (w_useAlu) r_y <= w_rbData;
                    case (w_op)
                        c_OP_MFHI: r_regs[w_ra] <= r_hi;
                        c_OP_MFLO: r_regs[w_ra] <= r_lo;
                        c_OP_LDI:  r_regs[w_ra] <= w_imm;
                        c_OP_LD:   r_mar <= w_rbData;
                        c_OP_ST: begin
                            r_mar <= w_rbData;
                            r_mdr <= w_raData;
                        end
                        default: ;
                    endcase
                end
                c_E1: begin
                    r_zHi <= w_aluHi;
                    r_zLo <= w_aluLo;
                end
                c_E2: begin
                    if (w_op == c_OP_MUL) begin
                        r_hi <= r_zHi;
                        r_lo <= r_zLo;
                    end else begin
                        r_regs[w_ra] <= r_zLo;
                    end
                end
                c_M1: if (mem_ack && w_op == c_OP_LD) r_mdr <= mem_rdata;
                c_M2: r_regs[w_ra] <= r_mdr;
                default: ;
            endcase
        end
    end

    // Requests decode straight from the state so reset drops them immediately.
    assign mem_rd     = (r_state == c_F1) || (r_state == c_M1 && w_op == c_OP_LD);
    assign mem_wr     = (r_state == c_M1) && (w_op == c_OP_ST);
    assign mem_addr   = r_mar;
    assign mem_wdata  = r_mdr;
    assign halted     = (r_state == c_HLT);
    assign illegal_op = (r_state == c_E0) && !w_legal;
    assign pc         = r_pc;
    assign ir         = r_ir;
    assign dbg_data   = r_regs[dbg_sel];

endmodule

`default_nettype wire

// File: tb/tb_bus_datapath_seq.sv
// ============================================================================
// Module      : tb_bus_datapath_seq
// Description : Directed self-checking bench for bus_datapath_seq with a
//               wait-state memory model; honours DATAPATH_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_datapath_seq;

    logic        r_clock = 1'b0;
    logic        r_clear = 1'b0;
    logic [3:0]  r_dbgSel = '0;
    logic [31:0] w_memAddr, w_memWdata, w_memRdata, w_pc, w_ir, w_dbgData;
    logic        w_memRd, w_memWr, w_memAck, w_halted, w_illegalOp;

    logic [31:0] r_progMem [64];
    logic [31:0] r_dataMem [64];
    int          r_waitCfg = 0;
    int          r_waitCnt;
    int          r_wrCount = 0;
    logic [31:0] r_wrAddr = '0, r_wrData = '0;
    int          r_illegalCnt = 0;
    int          r_bothHigh = 0;
    int          r_errors = 0;
    int          r_checks = 0;

    bus_datapath_seq dut (
        .clock      (r_clock),
        .clear      (r_clear),
        .mem_addr   (w_memAddr),
        .mem_wdata  (w_memWdata),
        .mem_rdata  (w_memRdata),
        .mem_rd     (w_memRd),
        .mem_wr     (w_memWr),
        .mem_ack    (w_memAck),
        .halted     (w_halted),
        .illegal_op (w_illegalOp),
        .pc         (w_pc),
        .ir         (w_ir),
        .dbg_sel    (r_dbgSel),
        .dbg_data   (w_dbgData)
    );

    always #5 r_clock = ~r_clock;

    // Words 64..127 are data RAM written by the store port; below is program ROM.
    assign w_memRdata = w_memAddr[6] ? r_dataMem[w_memAddr[5:0]] : r_progMem[w_memAddr[5:0]];
    assign w_memAck   = (w_memRd || w_memWr) && (r_waitCnt >= r_waitCfg);

    always @(posedge r_clock or negedge r_clear) begin
        if (!r_clear)                        r_waitCnt <= 0;
        else if ((w_memRd || w_memWr) && !w_memAck) r_waitCnt <= r_waitCnt + 1;
        else                                 r_waitCnt <= 0;
    end

    always @(posedge r_clock) begin
        if (w_memWr && w_memAck) begin
            r_dataMem[w_memAddr[5:0]] <= w_memWdata;
            r_wrCount <= r_wrCount + 1;
            r_wrAddr  <= w_memAddr;
            r_wrData  <= w_memWdata;
        end
        if (w_illegalOp)        r_illegalCnt <= r_illegalCnt + 1;
        if (w_memRd && w_memWr) r_bothHigh   <= r_bothHigh + 1;
    end

    function automatic logic [31:0] rIns(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic logic [31:0] ldi(logic [3:0] ra, logic [22:0] imm);
        return {5'd12, ra, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        assert (obs === exp) else begin
            r_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic readReg(input logic [3:0] idx, output logic [31:0] val);
        r_dbgSel = idx;
        #1;
        val = w_dbgData;
    endtask

    task automatic clearProg();
        for (int i = 0; i < 64; i++) r_progMem[i] = rIns(5'd31, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic doReset();
        r_clear = 1'b0;
        @(posedge r_clock);
        @(posedge r_clock);
        @(negedge r_clock);
        r_clear = 1'b1;
    endtask

    task automatic runUntilHalt(input int budget, output int cycles);
        cycles = 0;
        while (!w_halted && cycles < budget) begin
            @(posedge r_clock);
            #1;
            cycles++;
        end
        chk("halt_reached", {31'd0, w_halted}, 32'd1);
    endtask

    initial begin
        int          cyc, rdCyc, viol, illBefore;
        logic [31:0] v;

        // ---- 1: LDI/LDI/ADD/HALT, reset state, latency
        clearProg();
        r_progMem[0] = ldi(4'd1, 23'd5);
        r_progMem[1] = ldi(4'd2, 23'd7);
        r_progMem[2] = rIns(5'd0, 4'd3, 4'd1, 4'd2);
        r_progMem[3] = rIns(5'd31, 4'd0, 4'd0, 4'd0);
        r_waitCfg = 0;
        r_clear = 1'b0;
        @(posedge r_clock);
        #1;
        chk("rst_pc", w_pc, 32'd0);
        chk("rst_ir", w_ir, 32'd0);
        chk("rst_ctl", {28'd0, w_memRd, w_memWr, w_halted, w_illegalOp}, 32'd0);
        readReg(4'd1, v);
        chk("rst_r1", v, 32'd0);
        doReset();
        runUntilHalt(100, cyc);
        chk("t1_cycles", cyc, 32'd18);
        readReg(4'd3, v);
        chk("t1_r3", v, 32'd12);
        chk("t1_pc", w_pc, 32'd4);

        // ---- 2: SUB wrap-around and logical shift right
        clearProg();
        r_progMem[0] = ldi(4'd1, 23'd0);
        r_progMem[1] = ldi(4'd2, 23'd1);
        r_progMem[2] = rIns(5'd1, 4'd3, 4'd1, 4'd2);
        r_progMem[3] = ldi(4'd2, 23'd4);
        r_progMem[4] = rIns(5'd5, 4'd4, 4'd3, 4'd2);
        doReset();
        runUntilHalt(100, cyc);
        chk("t2_cycles", cyc, 32'd28);
        readReg(4'd3, v);
        chk("t2_sub", v, 32'hFFFF_FFFF);
        readReg(4'd4, v);
        chk("t2_shr", v, 32'h0FFF_FFFF);

        // ---- 3: MUL into HI:LO (or illegal when multiplier is absent)
        clearProg();
        r_progMem[0] = ldi(4'd1, 23'h10000);
        r_progMem[1] = ldi(4'd2, 23'h30000);
        r_progMem[2] = rIns(5'd7, 4'd7, 4'd1, 4'd2);
        r_progMem[3] = rIns(5'd8, 4'd4, 4'd0, 4'd0);
        r_progMem[4] = rIns(5'd9, 4'd5, 4'd0, 4'd0);
        illBefore = r_illegalCnt;
        doReset();
        runUntilHalt(100, cyc);
        readReg(4'd4, v);
`ifdef DATAPATH_MUL_EN
        chk("t3_hi", v, 32'd3);
        chk("t3_illegal", r_illegalCnt - illBefore, 32'd0);
        chk("t3_cycles", cyc, 32'd26);
`else
        chk("t3_hi", v, 32'd0);
        chk("t3_illegal", r_illegalCnt - illBefore, 32'd1);
        chk("t3_cycles", cyc, 32'd24);
`endif
        readReg(4'd5, v);
        chk("t3_lo", v, 32'd0);
        readReg(4'd7, v);
        chk("t3_r7", v, 32'd0);

        // ---- 4: fetch with 3 wait cycles
        clearProg();
        r_progMem[0] = ldi(4'd1, 23'd9);
        r_waitCfg = 3;
        doReset();
        cyc = 0;
        rdCyc = 0;
        viol = 0;
        @(posedge r_clock);
        #1;
        cyc++;
        while (w_memRd && rdCyc < 20) begin
            rdCyc++;
            if (w_memAddr !== 32'd0) viol++;
            @(posedge r_clock);
            #1;
            cyc++;
        end
        chk("t4_rd_cycles", rdCyc, 32'd4);
        chk("t4_addr_stable", viol, 32'd0);
        runUntilHalt(100, rdCyc);
        chk("t4_cycles", cyc + rdCyc, 32'd14);
        readReg(4'd1, v);
        chk("t4_r1", v, 32'd9);
        r_waitCfg = 0;

        // ---- 5: store then load through data RAM
        clearProg();
        r_progMem[0] = ldi(4'd3, 23'd12);
        r_progMem[1] = ldi(4'd5, 23'd100);
        r_progMem[2] = rIns(5'd11, 4'd3, 4'd5, 4'd0);
        r_progMem[3] = rIns(5'd10, 4'd6, 4'd5, 4'd0);
        doReset();
        runUntilHalt(100, cyc);
        chk("t5_cycles", cyc, 32'd23);
        chk("t5_wr_count", r_wrCount, 32'd1);
        chk("t5_wr_addr", r_wrAddr, 32'd100);
        chk("t5_wr_data", r_wrData, 32'd12);
        readReg(4'd6, v);
        chk("t5_r6", v, 32'd12);

        // ---- 6: asynchronous reset while a fetch waits for ack
        clearProg();
        r_progMem[0] = ldi(4'd1, 23'h55);
        doReset();
        repeat (4) @(posedge r_clock);
        #1;
        r_waitCfg = 20;
        readReg(4'd1, v);
        chk("t6_r1_pre", v, 32'h55);
        @(posedge r_clock);
        @(posedge r_clock);
        @(posedge r_clock);
        #1;
        chk("t6_rd_pre", {31'd0, w_memRd}, 32'd1);
        chk("t6_addr_pre", w_memAddr, 32'd1);
        #2;
        r_clear = 1'b0;
        #1;
        chk("t6_rd_async", {31'd0, w_memRd}, 32'd0);
        chk("t6_pc_async", w_pc, 32'd0);
        chk("t6_ir_async", w_ir, 32'd0);
        readReg(4'd1, v);
        chk("t6_r1_async", v, 32'd0);
        r_waitCfg = 0;
        @(negedge r_clock);
        r_clear = 1'b1;
        @(posedge r_clock);
        #1;
        chk("t6_refetch_rd", {31'd0, w_memRd}, 32'd1);
        chk("t6_refetch_addr", w_memAddr, 32'd0);
        runUntilHalt(100, cyc);
        readReg(4'd1, v);
        chk("t6_r1_post", v, 32'h55);
        chk("t6_pc_post", w_pc, 32'd2);

        chk("rd_wr_exclusive", r_bothHigh, 32'd0);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
Parametrised successor to the single-bus CPU datapath. It contains a register file, Y/Z/HI/LO, PC, IR, MAR and MDR, and a shared internal bus. A built-in T-state sequencer generates the bus control itself. The block fetches instructions from an external word-addressed memory over a req/ack handshake and executes register ALU, load/store and move operations until HALT.

Parameters:
WIDTH, 32, datapath, bus, register and memory word width (minimum 32).
NREGS, 16, number of general registers (power of 2, 2..32); REG_AW = clog2(NREGS).
SHAMT_W, clog2(WIDTH), number of R[rc] low bits used as the shift amount.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
clear  in  1  asynchronous, active-low reset.
mem_addr  out  WIDTH  memory word address (driven from MAR).
mem_wdata  out  WIDTH  store data (driven from MDR).
mem_rdata  in  WIDTH  read data, sampled in the ack cycle.
mem_rd  out  1  read request.
mem_wr  out  1  write request.
mem_ack  in  1  memory accepts/returns data this cycle.
halted  out  1  high after HALT executes.
illegal_op  out  1  one-cycle pulse on an undefined opcode.
pc  out  WIDTH  current PC.
ir  out  WIDTH  current IR.
dbg_sel  in  REG_AW  debug register select.
dbg_data  out  WIDTH  combinational R[dbg_sel].

Behaviour:
Reset (clear low) takes effect immediately, asynchronously:
- All registers, PC, IR, MAR, MDR, Y, Z, HI and LO go to 0.
- mem_rd, mem_wr, halted and illegal_op go to 0.
- State goes to F0.
- Any memory transaction in flight is abandoned.

IR format, from the MSB down:
- opcode = top 5 bits.
- ra, rb, rc = REG_AW bits each, in that order.
- imm = all bits below ra, zero-extended.

Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR: R[ra] = R[rb] op R[rc], modulo 2^WIDTH.
- 4 SHL, 5 SHR (logical): shift R[rb] by R[rc][SHAMT_W-1:0].
- 6 NOT: R[ra] = ~R[rb].
- 7 MUL: optional, see Optional Feature.
- 8 MFHI, 9 MFLO: R[ra] = HI / LO.
- 10 LD: R[ra] = mem[R[rb]].
- 11 ST: mem[R[rb]] = R[ra].
- 12 LDI: R[ra] = imm.
- 31 HALT.
- All other opcodes are illegal.

States, one bus transfer per cycle:
- F0: MAR <= PC; Z <= PC+1; PC <= Z path (PC+1, wraps at 2^WIDTH).
- F1: mem_rd=1 with mem_addr=MAR. Stay in F1 until mem_ack=1; in the ack cycle MDR <= mem_rdata, then go to F2.
- F2: IR <= MDR.
- E0 (decode):
  - ALU ops, MUL: Y <= R[rb], go to E1.
  - MFHI, MFLO, LDI: write R[ra], go to F0.
  - LD, ST: MAR <= R[rb]; for ST also MDR <= R[ra]; go to M1.
  - HALT: halted=1, go to HLT.
  - Illegal: illegal_op=1 for this cycle, go to F0.
- E1: Z(hi,lo) <= ALU(Y, R[rc]).
- E2: R[ra] <= Zlo (MUL: HI <= Zhi, LO <= Zlo, R[ra] unchanged), go to F0.
- M1: mem_rd (LD) or mem_wr (ST) held until ack.
  - LD: MDR <= mem_rdata at ack, go to M2.
  - ST: go to F0.
- M2: R[ra] <= MDR, go to F0.
- HLT: terminal; only reset leaves it.

Handshake rules:
- mem_addr/mem_wdata stay stable while a request is high.
- A request is high for at least 1 cycle and drops the cycle after ack.
- Zero-wait means ack in the first request cycle.
- mem_rd and mem_wr are never both high.

Latency with zero wait:
- ALU instruction: 6 cycles.
- MFHI, MFLO, LDI, illegal: 4 cycles.
- LD: 6 cycles; ST: 5 cycles.
- Each wait cycle adds 1.

Other rules:
- Writes to the same register read in an earlier state are visible next instruction.
- R0 is an ordinary register.
- pc reflects the already-incremented value from F1 onward.

Optional Feature:
Macro DATAPATH_MUL_EN.
- Defined: MUL computes the unsigned 2*WIDTH product of R[rb] and R[rc] into HI:LO in E1/E2, 6 cycles.
- Undefined: opcode 7 is illegal (illegal_op pulse, NOP, 4 cycles) and no multiplier is synthesised. HI/LO still exist and read 0 unless written.

Test Plan:
1. Reset, zero-wait memory, program LDI R1,5; LDI R2,7; ADD R3,R1,R2; HALT -> R3=12, halted=1, pc=4, ADD takes exactly 6 cycles.
2. R1=0, R2=1, SUB R3,R1,R2 -> R3=0xFFFFFFFF; then SHR R4,R3,R2 with R2=4 -> R4=0x0FFFFFFF.
3. DATAPATH_MUL_EN defined: R1=0x10000, R2=0x30000, MUL; MFHI R4; MFLO R5 -> R4=3, R5=0. Macro undefined: the same program gives one illegal_op pulse and R4=R5=0.
4. Fetch ack delayed 3 cycles -> mem_rd high 4 cycles with mem_addr constant, drops the next cycle, instruction completes 3 cycles later than the zero-wait case.
5. R3=12, R5=100: ST R3,(R5); LD R6,(R5) -> single mem_wr accept at addr 100 with wdata 12, then R6=12.
6. clear driven low during F1 while waiting for ack -> mem_rd falls without a clock edge, pc=0, all registers 0. After release, fetch restarts at address 0.
